// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm ringer slice.
//   alarm_state_e  : ringer FSM states
//   MODE_ALARM_SET : clock-mode code during which the alarm is being edited
//   BCD_W          : width of one packed-BCD time field
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

  localparam logic [1:0] MODE_ALARM_SET = 2'd2;
  localparam int         BCD_W          = 8;

endpackage

// File: rtl/alarm_ringer_if.sv
// Bus between the timekeeper/alarm-setting stage and the alarm ringer.
//   master : drives mode, time, alarm settings, sec_tick and buttons;
//            receives buzz/ringing/snoozed/snooze_used
//   slave  : the ringer side of the same signals
interface alarm_ringer_if;
  import alarm_pkg::*;

  logic [1:0]       mode;
  logic [BCD_W-1:0] cur_hour;
  logic [BCD_W-1:0] cur_minute;
  logic [BCD_W-1:0] cur_second;
  logic [BCD_W-1:0] alarm_hour;
  logic [BCD_W-1:0] alarm_minute;
  logic             alarm_en;
  logic             sec_tick;
  logic             stop;
  logic             snooze;
  logic             buzz;
  logic             ringing;
  logic             snoozed;
  logic [1:0]       snooze_used;

  modport master (
    output mode, cur_hour, cur_minute, cur_second, alarm_hour, alarm_minute,
    output alarm_en, sec_tick, stop, snooze,
    input  buzz, ringing, snoozed, snooze_used
  );

  modport slave (
    input  mode, cur_hour, cur_minute, cur_second, alarm_hour, alarm_minute,
    input  alarm_en, sec_tick, stop, snooze,
    output buzz, ringing, snoozed, snooze_used
  );

endinterface

// File: rtl/alarm_tone_gen.sv
// Square-wave buzzer generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : tone runs while high; buzz forced low otherwise
//   restart    : start a fresh period (buzz=1, counter cleared)
//   buzz       : tone output, period 2*TONE_DIV clocks
module alarm_tone_gen #(
  parameter int TONE_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic buzz
);

  localparam int             CW   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TONE_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_buzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_buzz <= 1'b0;
    end else if (restart) begin
      r_cnt  <= '0;
      r_buzz <= 1'b1;
    end else if (!enable) begin
      r_cnt  <= '0;
      r_buzz <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_buzz <= ~r_buzz;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign buzz = r_buzz;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: compares the running BCD time against the stored alarm,
// rings with a square-wave buzzer, supports stop, limited snooze and
// automatic timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alarm_ringer_if.slave (time/alarm/buttons in,
//                buzz/ringing/snoozed/snooze_used out)
module alarm_ringer
  import alarm_pkg::*;
#(
  parameter int TONE_DIV       = 4,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int SNOOZE_MAX     = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  alarm_ringer_if.slave  bus
);

  localparam int            RC_W      = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
  localparam int            SC_W      = $clog2(SNOOZE_MINUTES * 60 + 1);
  localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SECONDS - 1);
  localparam logic [SC_W-1:0] SNZ_LOAD  = SC_W'(SNOOZE_MINUTES * 60);
  localparam logic [1:0]      SNZ_MAX   = 2'(SNOOZE_MAX);

  alarm_state_e    r_state;
  alarm_state_e    w_nxt;
  logic [RC_W-1:0] r_ring_cnt;
  logic [SC_W-1:0] r_snz_cnt;
  logic [1:0]      r_snooze_used;

  logic r_match_q, r_trig;
  logic r_stop_q, r_stop_ev;
  logic r_snooze_q, r_snooze_ev;

  logic w_match, w_disable, w_enter_ring, w_buzz;

  assign w_disable = !bus.alarm_en || (bus.mode == MODE_ALARM_SET);
  assign w_match   = !w_disable
                   && (bus.cur_hour   == bus.alarm_hour)
                   && (bus.cur_minute == bus.alarm_minute)
                   && (bus.cur_second == 8'h00);

  // Trigger and button edges are registered as one-cycle event pulses, so
  // the FSM reacts on the edge after the one that first saw the condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_q   <= 1'b0;
      r_trig      <= 1'b0;
      r_stop_q    <= 1'b0;
      r_stop_ev   <= 1'b0;
      r_snooze_q  <= 1'b0;
      r_snooze_ev <= 1'b0;
    end else begin
      r_match_q   <= w_match;
      r_trig      <= w_match && !r_match_q;
      r_stop_q    <= bus.stop;
      r_stop_ev   <= bus.stop && !r_stop_q;
      r_snooze_q  <= bus.snooze;
      r_snooze_ev <= bus.snooze && !r_snooze_q;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:   if (r_trig) w_nxt = RING;
      RING: begin
        if (r_stop_ev)                                     w_nxt = IDLE;
        else if (r_snooze_ev && (r_snooze_used < SNZ_MAX)) w_nxt = SNOOZE;
        else if (bus.sec_tick && (r_ring_cnt == RING_LAST)) w_nxt = IDLE;
      end
      SNOOZE: begin
        if (r_stop_ev)                                      w_nxt = IDLE;
        else if (bus.sec_tick && (r_snz_cnt == SC_W'(1)))   w_nxt = RING;
      end
      default: w_nxt = IDLE;
    endcase
    if (w_disable) w_nxt = IDLE;
  end

  assign w_enter_ring = (w_nxt == RING) && (r_state != RING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ring_cnt    <= '0;
      r_snz_cnt     <= '0;
      r_snooze_used <= '0;
    end else begin
      r_state <= w_nxt;

      if (w_enter_ring)
        r_ring_cnt <= '0;
      else if ((r_state == RING) && bus.sec_tick && (r_ring_cnt != RING_LAST))
        r_ring_cnt <= r_ring_cnt + 1'b1;

      // A fresh alarm event (not a snooze expiry) resets the snooze budget.
      if ((r_state == IDLE) && (w_nxt == RING))
        r_snooze_used <= '0;
      else if ((r_state == RING) && (w_nxt == SNOOZE))
        r_snooze_used <= r_snooze_used + 2'd1;

      if ((r_state == RING) && (w_nxt == SNOOZE))
        r_snz_cnt <= SNZ_LOAD;
      else if ((r_state == SNOOZE) && bus.sec_tick && (r_snz_cnt != '0))
        r_snz_cnt <= r_snz_cnt - 1'b1;
    end
  end

  // Driven from the next state so buzz is already low on the cycle the FSM
  // leaves RING and already high on the cycle it enters.
  alarm_tone_gen #(
    .TONE_DIV (TONE_DIV)
  ) u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (w_nxt == RING),
    .restart (w_enter_ring),
    .buzz    (w_buzz)
  );

  assign bus.buzz        = w_buzz;
  assign bus.ringing     = (r_state == RING);
  assign bus.snoozed     = (r_state == SNOOZE);
  assign bus.snooze_used = r_snooze_used;

endmodule

// File: tb/tb_alarm_ringer.sv
module tb_alarm_ringer;
  import alarm_pkg::*;

  localparam int TONE_DIV       = 2;
  localparam int RING_SECONDS   = 5;
  localparam int SNOOZE_MINUTES = 1;
  localparam int SNOOZE_MAX     = 3;

  localparam logic [4:0] M_ALL   = 5'b11111;
  localparam logic [4:0] M_NOBZ  = 5'b01111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alarm_ringer_if bus ();

  alarm_ringer #(
    .TONE_DIV       (TONE_DIV),
    .RING_SECONDS   (RING_SECONDS),
    .SNOOZE_MINUTES (SNOOZE_MINUTES),
    .SNOOZE_MAX     (SNOOZE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [4:0] exp;
    logic [4:0] msk;
  } sb_t;

  sb_t sb_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output word {buzz, ringing, snoozed, snooze_used[1:0]}
  task automatic expect_out(input string tag, input logic b, input logic r,
                            input logic s, input logic [1:0] u, input logic [4:0] m);
    sb_t e;
    e.tag = tag;
    e.exp = {b, r, s, u};
    e.msk = m;
    sb_q.push_back(e);
  endtask

  task automatic observe();
    sb_t        e;
    logic [4:0] obs;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 8'(sb_q.size()), 8'd1);
    end else begin
      e   = sb_q.pop_front();
      obs = {bus.buzz, bus.ringing, bus.snoozed, bus.snooze_used};
      chk(e.tag, {3'b000, obs & e.msk}, {3'b000, e.exp & e.msk});
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      bus.sec_tick = 1'b1;
      step(1);
      bus.sec_tick = 1'b0;
      step(1);
    end
  endtask

  // Produce a fresh matching minute; returns just after RING entry.
  task automatic fire();
    bus.cur_second = 8'h01;
    step(2);
    bus.cur_second = 8'h00;
    step(2);
  endtask

  task automatic snooze_cycle();
    bus.snooze = 1'b1;
    step(2);
    bus.snooze = 1'b0;
    step(1);
    tick_n(SNOOZE_MINUTES * 60);
  endtask

  initial begin
    logic [3:0] pat;
    bus.mode         = 2'd0;
    bus.alarm_hour   = 8'h07;
    bus.alarm_minute = 8'h30;
    bus.alarm_en     = 1'b1;
    bus.cur_hour     = 8'h07;
    bus.cur_minute   = 8'h29;
    bus.cur_second   = 8'h59;
    bus.sec_tick     = 1'b0;
    bus.stop         = 1'b0;
    bus.snooze       = 1'b0;

    #2;
    expect_out("reset", 0, 0, 0, 2'd0, M_ALL);
    observe();
    step(2);
    rst_n = 1'b1;
    step(3);

    // Trigger at 07:30:00
    bus.cur_minute = 8'h30;
    bus.cur_second = 8'h00;
    expect_out("trig_edge1", 0, 0, 0, 2'd0, M_ALL);
    step(1);
    observe();
    expect_out("trig_edge2", 1, 1, 0, 2'd0, M_ALL);
    step(1);
    observe();
    pat = 4'b1001;
    for (int i = 3; i >= 0; i--) begin
      expect_out("buzz_wave", pat[i], 1, 0, 2'd0, M_ALL);
      step(1);
      observe();
    end
    tick_n(RING_SECONDS - 1);
    expect_out("ring_before_timeout", 0, 1, 0, 2'd0, M_NOBZ);
    observe();
    bus.sec_tick = 1'b1;
    expect_out("timeout", 0, 0, 0, 2'd0, M_ALL);
    step(1);
    bus.sec_tick = 1'b0;
    observe();
    expect_out("no_retrig_timeout", 0, 0, 0, 2'd0, M_ALL);
    step(6);
    observe();

    // Stop
    fire();
    bus.stop = 1'b1;
    expect_out("stop_edge1", 0, 1, 0, 2'd0, M_NOBZ);
    step(1);
    observe();
    expect_out("stop_edge2", 0, 0, 0, 2'd0, M_ALL);
    step(1);
    observe();
    bus.stop = 1'b0;
    expect_out("stop_no_retrig", 0, 0, 0, 2'd0, M_ALL);
    step(6);
    observe();

    // Snooze up to the limit
    fire();
    for (int s = 1; s <= SNOOZE_MAX; s++) begin
      bus.snooze = 1'b1;
      expect_out("snz_enter", 0, 0, 1, 2'(s), M_ALL);
      step(2);
      observe();
      bus.snooze = 1'b0;
      step(1);
      expect_out("snz_wait", 0, 0, 1, 2'(s), M_ALL);
      tick_n(SNOOZE_MINUTES * 60 - 1);
      observe();
      bus.sec_tick = 1'b1;
      expect_out("snz_expire", 1, 1, 0, 2'(s), M_ALL);
      step(1);
      bus.sec_tick = 1'b0;
      observe();
      step(1);
    end
    bus.snooze = 1'b1;
    expect_out("snz_over_max", 0, 1, 0, 2'd3, M_NOBZ);
    step(2);
    observe();
    bus.snooze = 1'b0;
    step(1);
    bus.stop = 1'b1;
    expect_out("snz_then_stop", 0, 0, 0, 2'd3, M_ALL);
    step(2);
    observe();
    bus.stop = 1'b0;
    step(1);

    // Stop and snooze rising together
    expect_out("refire_clears_used", 1, 1, 0, 2'd0, M_ALL);
    fire();
    observe();
    snooze_cycle();
    bus.stop   = 1'b1;
    bus.snooze = 1'b1;
    expect_out("stop_and_snooze", 0, 0, 0, 2'd1, M_ALL);
    step(2);
    observe();
    bus.stop   = 1'b0;
    bus.snooze = 1'b0;
    step(1);

    // Mode change during snooze, then disabled alarm at a matching time
    fire();
    bus.snooze = 1'b1;
    step(2);
    bus.snooze = 1'b0;
    step(1);
    bus.mode = MODE_ALARM_SET;
    expect_out("mode_to_idle", 0, 0, 0, 2'd1, M_ALL);
    step(1);
    observe();
    bus.cur_second = 8'h01;
    step(1);
    bus.mode = 2'd0;
    step(2);
    bus.alarm_en   = 1'b0;
    bus.cur_second = 8'h00;
    expect_out("disabled_no_ring", 0, 0, 0, 2'd1, M_ALL);
    step(6);
    observe();
    bus.cur_second = 8'h01;
    step(1);
    bus.alarm_en = 1'b1;
    step(2);

    // Asynchronous reset mid-ring, then release with match held
    fire();
    snooze_cycle();
    step(1);
    #3;
    expect_out("async_reset", 0, 0, 0, 2'd0, M_ALL);
    rst_n = 1'b0;
    #1;
    observe();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_out("rst_release_edge1", 0, 0, 0, 2'd0, M_ALL);
    step(1);
    observe();
    expect_out("rst_release_edge2", 1, 1, 0, 2'd0, M_ALL);
    step(1);
    observe();

    chk("sb_drain", 8'(sb_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_ringer.md
# alarm_ringer

Downstream consumer of the alarm-setting stage. Compares the running BCD time from the timekeeper against the stored alarm hour/minute. On a match it raises a ringing state and drives a square-wave buzzer, with support for stop, limited snooze and automatic timeout. Its outputs go to the buzzer pin and the status LEDs.

## Interface
- TONE_DIV, 4: clk cycles per buzzer half-period (≥1).
- RING_SECONDS, 60: seconds of ringing before auto-stop (≥1).
- SNOOZE_MINUTES, 5: snooze length in minutes (≥1).
- SNOOZE_MAX, 3: snoozes allowed per alarm event (≥1).
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  clock mode; 2'd2 = alarm-set mode.
- cur_hour, cur_minute, cur_second  in  8 each  current time, packed BCD.
- alarm_hour, alarm_minute  in  8 each  stored alarm time, packed BCD.
- alarm_en  in  1  alarm armed (level).
- sec_tick  in  1  one-cycle pulse per second from the timekeeper.
- stop, snooze  in  1 each  debounced, synchronized button levels; edge-detected internally.
- buzz  out  1  tone output.
- ringing  out  1  high in RING.
- snoozed  out  1  high in SNOOZE.
- snooze_used  out  2  snoozes consumed this event.

## Operation
- FSM states: IDLE, RING, SNOOZE. Reset puts the FSM in IDLE. On reset all outputs are 0 and all counters and edge registers are 0.
- match = alarm_en && mode!=2 && cur_hour==alarm_hour && cur_minute==alarm_minute && cur_second==8'h00. Comparison is on raw bits; no BCD validation.
- trigger = match && !match_q, where match_q is match registered. The alarm fires once per matching minute.
- IDLE → RING on trigger. On entry: ring_cnt=0, tone_cnt=0, buzz=1, snooze_used=0.
- RING:
  - buzz toggles each time tone_cnt reaches TONE_DIV-1; tone_cnt then wraps to 0.
  - ring_cnt increments on sec_tick.
  - If sec_tick arrives with ring_cnt==RING_SECONDS-1 → IDLE (timeout).
- RING, snooze rising edge with snooze_used<SNOOZE_MAX → SNOOZE. On entry: snooze_used+1, snz_cnt=SNOOZE_MINUTES*60, buzz=0.
- RING, snooze rising edge with snooze_used==SNOOZE_MAX: ignored; ringing continues.
- SNOOZE: snz_cnt decrements on sec_tick. If sec_tick arrives with snz_cnt==1 → RING with ring_cnt=0, tone_cnt=0, buzz=1. snooze_used is kept.
- stop rising edge in RING or SNOOZE → IDLE.
- In any state, alarm_en==0 or mode==2 → IDLE. This has the highest priority.
- Priority within a cycle: disable/mode > stop > snooze > timeout/snooze expiry > tick counting.
- A trigger arriving while in RING or SNOOZE is ignored.
- snooze_used is held in IDLE until the next trigger clears it.
- buzz is 0 in every state other than RING.

## Timing
- Trigger latency: match first true at edge N; ringing=1 and buzz=1 after edge N+1. match_q registers at N, the state changes at N+1.
- Button latency: button rises before edge N; edge registered at N; state changes at N+1; outputs update the same cycle as the state.
- Buzz period in RING is 2*TONE_DIV clocks. The first half-period starts at RING entry.
- Ring duration is exactly RING_SECONDS sec_tick pulses. Snooze duration is exactly SNOOZE_MINUTES*60 pulses.
- Asynchronous reset mid-ring: outputs go to 0 immediately, without waiting for a clock edge.
- ring_cnt needs clog2(RING_SECONDS) bits. snz_cnt needs clog2(SNOOZE_MINUTES*60+1) bits. Counters saturate and never wrap.

## Structure
- Shared package alarm_pkg holds:
  - the state enum {IDLE, RING, SNOOZE};
  - MODE_ALARM_SET=2'd2;
  - BCD_W=8.
- One sub-module, alarm_tone_gen, parameterized by TONE_DIV. Inputs: clk, rst_n, enable, restart. Output: buzz.
- Edge detection, FSM and counters live in alarm_ringer.

## Test plan
All scenarios use TONE_DIV=2, RING_SECONDS=5, SNOOZE_MINUTES=1, SNOOZE_MAX=3.
- Trigger: alarm 07:30, en=1, mode=0; time steps 07:29:59 → 07:30:00. Required: ringing=1 one cycle later; buzz toggles every 2 clocks; after 5 sec_ticks ringing=0 and buzz=0.
- Stop: while ringing, pulse stop. Required: ringing=0 two edges after the rise. cur_second held at 00 for further cycles does not retrigger.
- Snooze: snooze during RING → snoozed=1, snooze_used=1. After 60 sec_ticks → ringing=1 again. Repeat to snooze_used=3; a 4th snooze press leaves ringing=1.
- Simultaneous stop and snooze rise in the same cycle → IDLE, snooze_used unchanged.
- Mode/disable: mode=2 during SNOOZE → IDLE. alarm_en=0 at a matching time → no ring.
- Reset: assert rst_n=0 mid-RING, between clock edges. Required: buzz, ringing, snoozed and snooze_used are 0 immediately. Release reset while match is held → match_q=0, so a ring starts (documented behaviour).
